// File: rtl/imem_loader_pkg.sv
// Shared types, sizes and control-decode helper for the instruction-memory loader.
package imem_loader_pkg;

   localparam int unsigned IMEM_DEPTH  = 256;
   localparam int unsigned IMEM_ADDR_W = 8;
   localparam int unsigned IMEM_DATA_W = 16;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned CNT_W       = 16;

   // Loader states; 3-bit encodings shared with the rest of the core.
   typedef enum logic [2:0] {
      IL_HDR_HI = 3'd0,
      IL_HDR_LO = 3'd1,
      IL_DAT_HI = 3'd2,
      IL_DAT_LO = 3'd3,
      IL_START  = 3'd4,
      IL_RUN    = 3'd5,
      IL_ERR    = 3'd6
   } il_state_e;

   // Control outputs presented to the byte source and to PCPU.
   typedef struct packed {
      logic in_ready;
      logic busy;
      logic enable;
      logic start;
      logic err;
   } il_ctrl_t;

   // Moore decode of the control outputs for a given state.
   function automatic il_ctrl_t il_decode(input il_state_e s);
      il_ctrl_t c;
      c = '0;
      case (s)
         IL_HDR_HI, IL_HDR_LO, IL_DAT_HI, IL_DAT_LO: begin
            c.in_ready = 1'b1;
            c.busy     = 1'b1;
         end
         IL_START: begin
            c.start  = 1'b1;
            c.enable = 1'b1;
         end
         IL_RUN:  c.enable = 1'b1;
         IL_ERR:  c.err    = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: async read, sync write, async active-low clear of every entry.
module imem_ram
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = IMEM_ADDR_W,
   parameter int unsigned DATA_W = IMEM_DATA_W,
   parameter int unsigned DEPTH  = IMEM_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage: cleared on reset, one word written per enabled edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Fetch port sees the pre-write value when reading the word being written.
   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream into the instruction RAM,
// then releases PCPU with enable/start and serves instruction fetches.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = IMEM_ADDR_W,
   parameter int unsigned DATA_W = IMEM_DATA_W,
   parameter int unsigned DEPTH  = IMEM_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              reload,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_datain,
   output logic              enable,
   output logic              start,
   output logic              busy,
   output logic              err
);

   il_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  wptr_q, wptr_d;
   logic [BYTE_W-1:0]  hi_q, hi_d;
   logic [CNT_W-1:0]   hdr_c;
   logic               accept_c;
   logic               we_c;
   logic [DATA_W-1:0]  wdata_c;
   il_ctrl_t           ctrl_d;

   assign accept_c = in_valid & in_ready;
   assign hdr_c    = {cnt_q[CNT_W-1:BYTE_W], in_data};
   assign wdata_c  = DATA_W'({hi_q, in_data});
   assign ctrl_d   = il_decode(state_d);

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IL_HDR_HI;
         cnt_q   <= '0;
         wptr_q  <= '0;
         hi_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         hi_q    <= hi_d;
      end
   end

   // Control outputs registered from the next-state decode so they track the state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         in_ready <= 1'b1;
         busy     <= 1'b1;
         enable   <= 1'b0;
         start    <= 1'b0;
         err      <= 1'b0;
      end else begin
         in_ready <= ctrl_d.in_ready;
         busy     <= ctrl_d.busy;
         enable   <= ctrl_d.enable;
         start    <= ctrl_d.start;
         err      <= ctrl_d.err;
      end
   end

   // Next-state, counter, pointer and byte-latch logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wptr_d  = wptr_q;
      hi_d    = hi_q;
      we_c    = 1'b0;
      case (state_q)
         IL_HDR_HI: begin
            if (accept_c) begin
               cnt_d   = {in_data, cnt_q[BYTE_W-1:0]};
               state_d = IL_HDR_LO;
            end
         end
         IL_HDR_LO: begin
            if (accept_c) begin
               cnt_d = hdr_c;
               if (hdr_c == '0 || 17'(hdr_c) > 17'(DEPTH)) begin
                  state_d = IL_ERR;
               end else begin
                  wptr_d  = '0;
                  state_d = IL_DAT_HI;
               end
            end
         end
         IL_DAT_HI: begin
            if (accept_c) begin
               hi_d    = in_data;
               state_d = IL_DAT_LO;
            end
         end
         IL_DAT_LO: begin
            if (accept_c) begin
               we_c    = 1'b1;
               wptr_d  = wptr_q + ADDR_W'(1);
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = (cnt_q == CNT_W'(1)) ? IL_START : IL_DAT_HI;
            end
         end
         IL_START: state_d = IL_RUN;
         IL_RUN: begin
            if (reload) begin
               state_d = IL_HDR_HI;
            end
         end
         IL_ERR:  state_d = IL_ERR;
         default: state_d = IL_HDR_HI;
      endcase
   end

   // Instruction store.
   imem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clock (clock),
      .reset (reset),
      .we    (we_c),
      .waddr (wptr_q),
      .wdata (wdata_c),
      .raddr (i_addr),
      .rdata (i_datain)
   );

endmodule
